// File: rtl/tcm_load_ctrl_if.sv
// AXI-Stream slave bundle feeding the TCM load sequencer.
// The master side drives data; the slave side answers with tready.
interface tcm_load_ctrl_if #(
  parameter int C_S_AXIS_TDATA_WIDTH = 32
);
  logic [C_S_AXIS_TDATA_WIDTH-1:0] tdata;
  logic                            tvalid;
  logic                            tlast;
  logic                            tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/tcm_load_ctrl.sv
// Fills a programmed, wrapping TCM window from an AXI-Stream packet.
// Enforces the programmed length against TLAST and reports sticky status.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | waiting for a start edge; stream not accepted
//   LOAD  | writing accepted beats to consecutive TCM addresses
//   DRAIN | length reached without tlast; discard until tlast
//   DONE  | one-cycle completion, done_irq high
module tcm_load_ctrl #(
  parameter int C_S_AXIS_TDATA_WIDTH = 32
) (
  input  logic                            s_axis_aclk,
  input  logic                            s_axis_aresetn,
  input  logic [31:0]                     ctrl_word,
  tcm_load_ctrl_if.slave                  s_axis,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0] tcm_wdata,
  output logic                            tcm_wr_en,
  output logic [4:0]                      tcm_addr_out,
  output logic [31:0]                     status_word,
  output logic                            done_irq
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t     state;
  logic       start_q;
  logic       busy;
  logic       done;
  logic       early_tlast;
  logic       overrun;
  logic       aborted;
  logic [4:0] addr;
  logic [4:0] len_m1;
  logic [5:0] count;

  logic start_edge;
  logic abort;
  logic beat;
  logic last_word;
  logic unused_ctrl;

  assign start_edge = ctrl_word[0] & ~start_q;
  assign abort      = ctrl_word[1];
  assign beat       = s_axis.tvalid & s_axis.tready;
  assign last_word  = (count == {1'b0, len_m1});
  assign unused_ctrl = ^{ctrl_word[31:21], ctrl_word[15:13], ctrl_word[7:2]};

  assign s_axis.tready = (state == LOAD) || (state == DRAIN);
  assign status_word   = {18'd0, count, 3'd0, aborted, overrun, early_tlast, done, busy};

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state        <= IDLE;
      start_q      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      early_tlast  <= 1'b0;
      overrun      <= 1'b0;
      aborted      <= 1'b0;
      addr         <= '0;
      len_m1       <= '0;
      count        <= '0;
      tcm_wr_en    <= 1'b0;
      tcm_addr_out <= '0;
      tcm_wdata    <= '0;
      done_irq     <= 1'b0;
    end else begin
      start_q   <= ctrl_word[0];
      tcm_wr_en <= 1'b0;
      done_irq  <= 1'b0;
      case (state)
        IDLE: begin
          if (start_edge && !abort) begin
            addr        <= ctrl_word[12:8];
            len_m1      <= ctrl_word[20:16];
            count       <= '0;
            done        <= 1'b0;
            early_tlast <= 1'b0;
            overrun     <= 1'b0;
            aborted     <= 1'b0;
            busy        <= 1'b1;
            state       <= LOAD;
          end
        end
        LOAD: begin
          // A beat coinciding with abort is still committed to the TCM.
          if (beat) begin
            tcm_wr_en    <= 1'b1;
            tcm_addr_out <= addr;
            tcm_wdata    <= s_axis.tdata;
            addr         <= addr + 5'd1;
            count        <= count + 6'd1;
          end
          if (abort) begin
            state   <= IDLE;
            busy    <= 1'b0;
            aborted <= 1'b1;
          end else if (beat) begin
            if (last_word) begin
              if (s_axis.tlast) begin
                state    <= DONE;
                done_irq <= 1'b1;
              end else begin
                overrun <= 1'b1;
                state   <= DRAIN;
              end
            end else if (s_axis.tlast) begin
              early_tlast <= 1'b1;
              state       <= DONE;
              done_irq    <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (abort) begin
            state   <= IDLE;
            busy    <= 1'b0;
            aborted <= 1'b1;
          end else if (beat && s_axis.tlast) begin
            state    <= DONE;
            done_irq <= 1'b1;
          end
        end
        DONE: begin
          // done is set on leaving DONE so an abort seen here can suppress it.
          state <= IDLE;
          busy  <= 1'b0;
          if (abort) aborted <= 1'b1;
          else       done    <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/tcm_load_ctrl.md
# tcm_load_ctrl

Sequencer that owns the TCM write port and fills a programmed address window from the AXI-Stream input. It sits between the AXI-Lite control register (ctrl_word) and the 32-entry TCM. It starts a load on a host command, writes stream words to consecutive TCM addresses with wrap-around, and enforces the programmed length against TLAST. It reports progress and errors in a status word and pulses an interrupt when a load finishes.

## Interface
- C_S_AXIS_TDATA_WIDTH, 32, stream and TCM data width.
- s_axis_aclk  in  1  single clock for the whole block.
- s_axis_aresetn  in  1  asynchronous, active-low reset.
- ctrl_word  in  32  host control:
  - [0] start: a rising edge starts a load.
  - [1] abort: level.
  - [12:8] base address.
  - [20:16] length-1, giving 1..32 words.
  - other bits ignored.
- s_axis_tdata  in  C_S_AXIS_TDATA_WIDTH  stream data.
- s_axis_tvalid  in  1  stream valid.
- s_axis_tlast  in  1  end of packet.
- s_axis_tready  out  1  stream ready.
- tcm_wdata  out  C_S_AXIS_TDATA_WIDTH  TCM write data.
- tcm_wr_en  out  1  TCM write strobe, one per word.
- tcm_addr_out  out  5  TCM address.
- status_word  out  32  status bits:
  - [0] busy.
  - [1] done.
  - [2] early_tlast.
  - [3] overrun.
  - [4] aborted.
  - [13:8] words written, 0..32.
  - other bits 0.
- done_irq  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, LOAD, DRAIN, DONE.
- start_q registers ctrl_word[0] every cycle. A start edge is ctrl_word[0] & ~start_q.
- IDLE:
  - s_axis_tready=0.
  - On a start edge with abort=0: latch base into addr and length-1 into len_m1, set count=0, clear status bits [4:1], go to LOAD.
- LOAD:
  - s_axis_tready=1. A beat is tvalid & tready.
  - Per beat: write tdata at addr, addr = addr+1 mod 32 (31 wraps to 0), count = count+1.
  - Beat with count==len_m1 and tlast=1: go to DONE.
  - Beat with count==len_m1 and tlast=0: set overrun, go to DRAIN.
  - Beat with count<len_m1 and tlast=1: set early_tlast, go to DONE.
- DRAIN:
  - s_axis_tready=1. Beats are accepted and discarded; no TCM writes.
  - A tlast beat goes to DONE.
- DONE:
  - Lasts one cycle. done_irq=1; set the sticky done bit; go to IDLE.
- Abort:
  - abort=1 in LOAD, DRAIN or DONE: next state is IDLE, set aborted, do not set done, no done_irq.
  - A beat accepted in the same cycle that abort is sampled is still written.
  - A DONE cycle that sees abort still drives done_irq for that cycle but does not set done.
- Start edges while busy are ignored.
- A start edge in IDLE with abort=1 is ignored.
- Sticky bits [4:1] hold until the next accepted start.
- Length 32 with any base is legal and covers the whole TCM, wrapping as needed.

## Timing
- Reset (async assert, sync release): state=IDLE and start_q=0.
  - Outputs: s_axis_tready=0, tcm_wr_en=0, tcm_addr_out=0, tcm_wdata=0, status_word=0, done_irq=0.
- All outputs are registered except s_axis_tready, which decodes state: 1 in LOAD and DRAIN only.
- Start edge sampled in cycle N: LOAD and tready=1 from cycle N+1.
- Beat accepted in cycle N: tcm_wr_en=1 in cycle N+1, with tcm_addr_out and tcm_wdata for that beat. Back-to-back beats give back-to-back writes.
- tcm_addr_out and tcm_wdata hold their last values while tcm_wr_en=0.
- Final beat in cycle N: DONE and done_irq=1 in cycle N+1, coinciding with the final write; busy=0 and IDLE in cycle N+2.
- busy is registered: 1 from cycle N+1 after the start edge until the cycle after DONE.
- status_word[13:8] updates in the same cycle as the matching tcm_wr_en.
- Reset asserted mid-load: immediate return to reset values; the in-flight write is dropped.

## Test plan
- Base 4, length-1=3, four beats 0xA0..0xA3 with tlast on the 4th:
  - Writes to addresses 4,5,6,7 at one cycle per beat.
  - done_irq pulses once; status_word = 0x0000_0402.
- Base 30, length-1=3, four beats with tlast on the 4th:
  - Addresses 30,31,0,1 (wrap-around).
  - count=4; done set.
- Base 0, length-1=7, tlast on the 3rd beat:
  - Exactly 3 writes; early_tlast=1, done=1, count=3.
  - tready=0 after DONE.
- Base 0, length-1=1, five beats with tlast on the 5th:
  - 2 writes; beats 3-5 accepted without writes; overrun=1, done=1.
- Abort asserted after 2 of 8 beats:
  - No further writes; aborted=1, done=0, no done_irq.
  - A new start edge then runs a clean load and clears aborted.
- Start held high across a load, and tvalid gaps mid-load:
  - Only one load starts.
  - Writes follow each beat by exactly one cycle.
  - Async reset mid-load returns all outputs to 0 at once.
